// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low patterns, bit0 = a .. bit6 = g; entry 15 (F) is listed first.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

endpackage

// File: rtl/hex_digit_decoder.sv
// Nibble to active-low seven-segment pattern, shared by all digits.
module hex_digit_decoder
  import seg_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_n_o
);

  assign seg_n_o = SEG_TABLE[hex_i];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with tear-free frame commits.
// Optional: define LEADING_ZERO_BLANK_EN to blank digits above the top nonzero nibble.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic                  load,
  output logic                  pending,
  output logic [DIGITS-1:0]     digit_sel_n,
  output logic [6:0]            seg_n,
  output logic                  frame_start
);

  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX);
  localparam int IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_SHOW  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  scan_state_e                 state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [IW-1:0]               idx_q, idx_d;
  logic [DIGITS-1:0][3:0]      pend_val_q, pend_val_d;
  logic [DIGITS-1:0][3:0]      shown_q, shown_d;
  logic                        pending_q, pending_d;
  logic [DIGITS-1:0]           sel_q, sel_d;
  logic [6:0]                  seg_q, seg_d;
  logic                        fs_q, fs_d;
  logic                        wrap;
  logic [3:0]                  dec_in;
  logic [6:0]                  dec_seg;
  logic                        lz_blank;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= BLANK;
      cnt_q      <= CNT_BLANK;
      idx_q      <= '0;
      pend_val_q <= '0;
      shown_q    <= '0;
      pending_q  <= 1'b0;
      sel_q      <= '1;
      seg_q      <= SEG_BLANK;
      fs_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pend_val_q <= pend_val_d;
      shown_q    <= shown_d;
      pending_q  <= pending_d;
      sel_q      <= sel_d;
      seg_q      <= seg_d;
      fs_q       <= fs_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - CW'(1);
    idx_d   = idx_q;
    wrap    = 1'b0;
    if (cnt_q == '0) begin
      if (state_q == BLANK) begin
        state_d = SHOW;
        cnt_d   = CNT_SHOW;
      end else begin
        state_d = BLANK;
        cnt_d   = CNT_BLANK;
        wrap    = (idx_q == IDX_LAST);
        idx_d   = wrap ? '0 : idx_q + IW'(1);
      end
    end
    // The registered frame_start cycle is the commit point, so a load in
    // that same cycle queues behind the value being committed.
    shown_d    = (fs_q && pending_q) ? pend_val_q : shown_q;
    pend_val_d = pend_val_q;
    if (load) pend_val_d = value_in;
    pending_d  = load | (pending_q & ~fs_q);
  end

  always_comb begin
    dec_in = '0;
    for (int i = 0; i < DIGITS; i++)
      if (idx_d == IW'(i)) dec_in = shown_d[i];
  end

  hex_digit_decoder u_dec (
    .hex_i   (dec_in),
    .seg_n_o (dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic [IW-1:0] msnz;
  always_comb begin
    msnz = '0;
    for (int i = 1; i < DIGITS; i++)
      if (shown_d[i] != 4'h0) msnz = IW'(i);
  end
  assign lz_blank = (idx_d > msnz);
`else
  assign lz_blank = 1'b0;
`endif

  always_comb begin
    sel_d = '1;
    seg_d = SEG_BLANK;
    fs_d  = wrap;
    if (state_d == SHOW) begin
      for (int i = 0; i < DIGITS; i++)
        if (idx_d == IW'(i)) sel_d[i] = 1'b0;
      seg_d = lz_blank ? SEG_BLANK : dec_seg;
    end
  end

  assign pending     = pending_q;
  assign digit_sel_n = sel_q;
  assign seg_n       = seg_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: frame-position model plus directed literals.
module tb_seg_scan_ctrl;

  localparam int DIGITS = 4;
  localparam int RDIV   = 4;
  localparam int BLK    = 2;
  localparam int SLOT   = BLK + RDIV;
  localparam int FRAME  = DIGITS * SLOT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value_in = '0;
  logic        pending, frame_start;
  logic [3:0]  digit_sel_n;
  logic [6:0]  seg_n;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  seg_scan_ctrl #(.DIGITS(DIGITS), .REFRESH_DIV(RDIV), .BLANK_CYCLES(BLK)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .value_in    (value_in),
    .load        (load),
    .pending     (pending),
    .digit_sel_n (digit_sel_n),
    .seg_n       (seg_n),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_dec(input logic [3:0] h);
    case (h)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Model: position in frame follows from cycles since reset; the displayed
  // value changes only at frame boundaries.
  bit          m_valid = 1'b0;
  int          m_t = 0;
  bit          m_pend = 1'b0;
  logic [15:0] m_pval = '0;
  logic [15:0] m_shown = '0;

  initial forever begin
    int p, d, q;
    logic [3:0] e_sel;
    logic [6:0] e_seg;
    @(negedge clk);
    if (m_valid) begin
      p = m_t % FRAME;
      d = p / SLOT;
      q = p % SLOT;
      e_sel = 4'hF;
      e_seg = 7'h7F;
      if (q >= BLK) begin
        e_sel[d] = 1'b0;
        e_seg = ref_dec(4'((m_shown >> (4*d)) & 16'hF));
`ifdef LEADING_ZERO_BLANK_EN
        if (d > 0 && (m_shown >> (4*d)) == 16'h0) e_seg = 7'h7F;
`endif
      end
      chk("model_sel", 32'(digit_sel_n), 32'(e_sel));
      chk("model_seg", 32'(seg_n), 32'(e_seg));
      chk("model_fs", 32'(frame_start), 32'(m_t > 0 && p == 0));
      chk("model_pending", 32'(pending), 32'(m_pend));
    end
    if (!rst_n) begin
      m_valid = 1'b1; m_t = 0; m_pend = 1'b0; m_pval = '0; m_shown = '0;
    end else if (m_valid) begin
      if (m_t > 0 && m_t % FRAME == 0 && m_pend) begin
        m_shown = m_pval;
        m_pend  = 1'b0;
      end
      if (load) begin
        m_pval = value_in;
        m_pend = 1'b1;
      end
      m_t++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  task automatic pulse_load(input logic [15:0] v);
    value_in = v;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    chk("rst_sel", 32'(digit_sel_n), 32'h0F);
    chk("rst_seg", 32'(seg_n), 32'h7F);
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_fs", 32'(frame_start), 32'h0);
    goto(2);
    chk("d0_sel", 32'(digit_sel_n), 32'b1110);
    chk("d0_seg_zero", 32'(seg_n), 32'b1000000);
    goto(24);
    chk("fs_first", 32'(frame_start), 32'h1);

    goto(30);
    pulse_load(16'hA5F3);
    chk("a5f3_pending", 32'(pending), 32'h1);
    goto(49);
    chk("a5f3_cleared", 32'(pending), 32'h0);
    goto(50);
    chk("a5f3_d0", 32'(seg_n), 32'b0110000);
    goto(56);
    chk("a5f3_d1", 32'(seg_n), 32'b0001110);
    goto(62);
    chk("a5f3_d2", 32'(seg_n), 32'b0010010);
    goto(68);
    chk("a5f3_d3", 32'(seg_n), 32'b0001000);

    goto(75);
    pulse_load(16'h1111);
    goto(90);
    pulse_load(16'h2222);
    goto(98);
    chk("last_load_wins", 32'(seg_n), 32'b0100100);

    goto(100);
    pulse_load(16'h3333);
    goto(120);
    chk("fs_on_load", 32'(frame_start), 32'h1);
    pulse_load(16'h4444);
    chk("pending_through_commit", 32'(pending), 32'h1);
    goto(122);
    chk("old_commits", 32'(seg_n), 32'b0110000);
    goto(145);
    chk("new_committed", 32'(pending), 32'h0);
    goto(146);
    chk("new_shows", 32'(seg_n), 32'b0011001);

    goto(150);
    pulse_load(16'h00A5);
    goto(170);
    chk("lz_d0", 32'(seg_n), 32'b0010010);
    goto(176);
    chk("lz_d1", 32'(seg_n), 32'b0001000);
    goto(182);
    chk("lz_d2_sel", 32'(digit_sel_n), 32'b1011);
`ifdef LEADING_ZERO_BLANK_EN
    chk("lz_d2_seg", 32'(seg_n), 32'h7F);
`else
    chk("lz_d2_seg", 32'(seg_n), 32'b1000000);
`endif
    goto(195);
    pulse_load(16'h0000);
    goto(218);
    chk("zero_d0", 32'(seg_n), 32'b1000000);
    goto(224);
`ifdef LEADING_ZERO_BLANK_EN
    chk("zero_d1", 32'(seg_n), 32'h7F);
`else
    chk("zero_d1", 32'(seg_n), 32'b1000000);
`endif

    goto(245);
    pulse_load(16'h7777);
    goto(255);
    chk("pre_rst_d2", 32'(digit_sel_n), 32'b1011);
    rst_n = 1'b0;
    tick();
    chk("midrst_sel", 32'(digit_sel_n), 32'h0F);
    chk("midrst_seg", 32'(seg_n), 32'h7F);
    chk("midrst_pending", 32'(pending), 32'h0);
    rst_n = 1'b1;
    cyc = 0;
    goto(1);
    chk("restart_blank", 32'(digit_sel_n), 32'h0F);
    goto(2);
    chk("restart_d0", 32'(digit_sel_n), 32'b1110);
    chk("restart_seg", 32'(seg_n), 32'b1000000);
    goto(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for a bank of common-anode seven-segment digits. It latches a packed hex value and steps through the digits one at a time. For each digit it drives the anode select and the active-low segment pattern, with a dead-time blanking interval between digits to suppress ghosting. It sits between the register or bus side of the design, which supplies values to display, and the board display pins. It owns the single per-nibble hex-to-segment decode that all digits share.

## Interface
Parameters:
- DIGITS, 4: number of multiplexed digits (≥1).
- REFRESH_DIV, 50000: clock cycles each digit is lit per visit (≥2).
- BLANK_CYCLES, 500: dead-time cycles with all anodes off before each digit (≥1).

Ports:
- clk  in  1: sole clock, rising edge.
- rst_n  in  1: reset; synchronous, active-low.
- value_in  in  4*DIGITS: packed nibbles; nibble i drives digit i, with digit 0 the least significant.
- load  in  1: one-cycle strobe that captures value_in into the pending register.
- pending  out  1: high while a captured value waits for the frame boundary.
- digit_sel_n  out  DIGITS: anode enables, active-low, one-hot-low or all-high.
- seg_n  out  7: segments, active-low; bit0 = a … bit6 = g.
- frame_start  out  1: one-cycle pulse when digit 0 enters BLANK.

## Operation
- FSM states: BLANK, SHOW. A down-counter `cnt` and a digit index `idx` run alongside the FSM.
- BLANK:
  - digit_sel_n is all ones and seg_n = 7'h7F.
  - Lasts BLANK_CYCLES cycles, then goes to SHOW and reloads cnt.
- SHOW:
  - digit_sel_n[idx] = 0 and all other anodes are 1.
  - seg_n = decode(shown[idx]).
  - Lasts REFRESH_DIV cycles, then goes to BLANK and sets idx = idx+1.
  - idx wraps from DIGITS-1 to 0.
- Decode table (seg_n):
  - 0 → 1000000, 1 → 1111001, 2 → 0100100, 3 → 0110000
  - 4 → 0011001, 5 → 0010010, 6 → 0000010, 7 → 1111000
  - 8 → 0000000, 9 → 0010000, A → 0001000, b → 0000011
  - C → 1000110, d → 0100001, E → 0000110, F → 0001110
- Value path:
  - On load, value_in goes to the pending register and pending is set to 1.
  - The commit event is the cycle idx wraps to 0 (the BLANK entry that also pulses frame_start). On commit, if pending = 1, the pending register is copied to shown and pending is cleared. Displayed frames therefore never tear.
  - If load and commit occur in the same cycle, the old pending value commits and the new value becomes pending (pending stays 1).
  - If load repeats while pending = 1, the last load wins.
- cnt width is $clog2(max(REFRESH_DIV, BLANK_CYCLES)). No other arithmetic is performed.

## Timing
- Reset values:
  - state = BLANK, idx = 0, cnt = BLANK_CYCLES-1.
  - shown = 0, pending register = 0, pending = 0.
  - digit_sel_n = all ones, seg_n = 7'h7F, frame_start = 0.
- All outputs are registered. Anode and segment changes land on the same edge, so there is no glitch between them.
- Frame period is DIGITS×(BLANK_CYCLES+REFRESH_DIV) cycles.
- Load-to-display latency: from 1 cycle up to 1 frame, to the next commit, plus BLANK_CYCLES before digit 0 lights.
- Reset asserted mid-frame returns every output to its reset value on the next edge and discards the pending value.
- DIGITS = 1: commit occurs at every BLANK entry.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - Digits above the most significant nonzero nibble of shown output seg_n = 7'h7F during SHOW. The anode is still enabled, so timing is unchanged.
  - Digit 0 is always shown, so a value of zero displays "0".
- LEADING_ZERO_BLANK_EN undefined: every digit is decoded.

## Structure
- Package seg_pkg holds:
  - the state enum (BLANK, SHOW)
  - SEG_BLANK = 7'h7F
  - the decode table constants
- One combinational sub-module, hex_digit_decoder: 4-bit input to 7-bit active-low output. It is instantiated once and driven by shown[idx].

## Test plan
Use DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=2 (frame = 24 cycles).
- Reset, then run 24 cycles with no load → each anode goes low for exactly 4 cycles in the order 0,1,2,3, with 2 all-high cycles before each; seg_n = 1000000 while lit; frame_start pulses every 24 cycles.
- Load 16'hA5F3 mid-frame → pending = 1 until the next frame_start, then digits 0..3 show 0110000, 0001110, 0010010, 0001000.
- Load 16'h1111 then 16'h2222 within one frame → only 2222 is ever displayed; digit 0 shows 0100100.
- Load on the exact frame_start cycle while a value is already pending → the old value displays in that frame, the new value in the next; pending stays high through the first commit.
- With LEADING_ZERO_BLANK_EN, load 16'h00A5 → digits 3 and 2 show 7F, digits 1 and 0 show 0001000 and 0010010; loading 16'h0000 → only digit 0 shows 1000000.
- Assert rst_n low during SHOW of digit 2 → next edge gives digit_sel_n = 4'hF, seg_n = 7F, pending = 0; scanning restarts at digit 0 after 2 BLANK cycles.
